// File: rtl/cas_player_if.sv
// Byte stream into the cassette player: valid/ready handshake, one byte per transfer.
interface cas_player_if;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/cas_player.sv
// FSK cassette transmitter: one held byte + shift register, bit 1 = F1 cycle, bit 0 = F0 cycle, LSB first.
// Accepted byte drives cas_out high two edges later (motor on); din_ready drops while a byte is held.
module cas_player #(
  parameter int CLK_HZ = 50000000,
  parameter int F1_HZ  = 2400,
  parameter int F0_HZ  = 1200
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         motor,
  cas_player_if.slave  in_if,
  output logic         cas_out,
  output logic         busy,
  output logic         byte_done,
  output logic         underrun
);

  localparam int H1 = CLK_HZ / (2 * F1_HZ);
  localparam int H0 = CLK_HZ / (2 * F0_HZ);
  localparam int CW = $clog2(H0);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t        state;
  logic [7:0]    hold;
  logic          hold_full;
  logic [7:0]    shift;
  logic [2:0]    idx;
  logic [CW-1:0] cnt;

  function automatic logic [CW-1:0] half_m1(input logic b);
    return b ? CW'(H1 - 1) : CW'(H0 - 1);
  endfunction

  assign in_if.din_ready = ~hold_full;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      hold      <= '0;
      hold_full <= 1'b0;
      shift     <= '0;
      idx       <= '0;
      cnt       <= '0;
      cas_out   <= 1'b0;
      busy      <= 1'b0;
      byte_done <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      underrun  <= 1'b0;

      // Accept and load are mutually exclusive: one needs hold empty, the other full.
      if (in_if.din_valid && !hold_full) begin
        hold      <= in_if.din;
        hold_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          cas_out <= 1'b0;
          busy    <= 1'b0;
          if (motor && hold_full) begin
            shift     <= hold;
            hold_full <= 1'b0;
            idx       <= '0;
            cnt       <= half_m1(hold[0]);
            state     <= HIGH;
            cas_out   <= 1'b1;
            busy      <= 1'b1;
          end
        end

        HIGH: begin
          if (motor) begin
            if (cnt == '0) begin
              cnt     <= half_m1(shift[0]);
              state   <= LOW;
              cas_out <= 1'b0;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
        end

        LOW: begin
          if (motor) begin
            if (cnt != '0) begin
              cnt <= cnt - CW'(1);
            end else if (idx != 3'd7) begin
              shift   <= shift >> 1;
              idx     <= idx + 3'd1;
              cnt     <= half_m1(shift[1]);
              state   <= HIGH;
              cas_out <= 1'b1;
            end else begin
              byte_done <= 1'b1;
              // Chain straight into the held byte so there is no gap between bytes.
              if (hold_full) begin
                shift     <= hold;
                hold_full <= 1'b0;
                idx       <= '0;
                cnt       <= half_m1(hold[0]);
                state     <= HIGH;
                cas_out   <= 1'b1;
              end else begin
                underrun <= 1'b1;
                state    <= IDLE;
                busy     <= 1'b0;
              end
            end
          end
        end

        default: begin
          state   <= IDLE;
          cas_out <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cas_player.sv
// Directed bench for cas_player at CLK_HZ=48000 (H1=10, H0=20); outputs sampled on the falling edge.
module tb_cas_player;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic motor = 1'b0;
  logic cas_out, busy, byte_done, underrun;

  int n_chk = 0;
  int n_err = 0;
  int bd_cnt = 0;
  int ur_cnt = 0;

  cas_player_if u_if();

  cas_player #(.CLK_HZ(48000), .F1_HZ(2400), .F0_HZ(1200)) dut (
    .clk       (clk),
    .reset     (reset),
    .motor     (motor),
    .in_if     (u_if),
    .cas_out   (cas_out),
    .busy      (busy),
    .byte_done (byte_done),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (byte_done === 1'b1) bd_cnt++;
    if (underrun === 1'b1) ur_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int half_len(input logic b);
    return b ? 10 : 20;
  endfunction

  // Called at a falling edge; returns the run length of level lvl while busy, and cycles waited for it.
  task automatic get_run(input logic lvl, output int n, output int w);
    w = 0;
    n = 0;
    while (!(cas_out === lvl && busy === 1'b1) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    while (cas_out === lvl && busy === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int t = 0;
    u_if.din       = b;
    u_if.din_valid = 1'b1;
    while (u_if.din_ready !== 1'b1 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("send_wait", 32'(t < 5000), 1);
    @(posedge clk);
    #1 u_if.din_valid = 1'b0;
    @(negedge clk);
    chk("rdy_after_acc", 32'(u_if.din_ready), 0);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!(busy === 1'b0 && u_if.din_ready === 1'b1) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("idle_wait", 32'(t < 5000), 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n, w, bd0, ur0, bad;
    logic [7:0] pat;
    logic [7:0] v;

    // Reset held with a byte offered
    u_if.din       = 8'hA5;
    u_if.din_valid = 1'b1;
    motor          = 1'b1;
    reset          = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cas", 32'(cas_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rdy", 32'(u_if.din_ready), 1);
    chk("rst_bd", 32'(byte_done), 0);
    chk("rst_ur", 32'(underrun), 0);
    reset = 1'b1;
    @(posedge clk);
    #1 u_if.din_valid = 1'b0;
    @(negedge clk);
    chk("rel_accept", 32'(u_if.din_ready), 0);
    chk("rel_busy", 32'(busy), 0);
    @(negedge clk);
    chk("lat_cas", 32'(cas_out), 1);

    // Single byte 0xA5
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      get_run(1'b1, n, w);
      chk("a5_hi", 32'(n), 32'(half_len(pat[i])));
      get_run(1'b0, n, w);
      chk("a5_lo", 32'(n), 32'(half_len(pat[i])));
    end
    chk("a5_bd", 32'(byte_done), 1);
    chk("a5_ur", 32'(underrun), 1);
    chk("a5_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    chk("a5_bd_cnt", 32'(bd_cnt), 1);
    chk("a5_ur_cnt", 32'(ur_cnt), 1);

    // Back-to-back 0x00 then 0xFF
    bd0 = bd_cnt;
    ur0 = ur_cnt;
    fork
      begin
        send(8'h00);
        send(8'hFF);
      end
      begin
        for (int k = 0; k < 16; k++) begin
          v = (k < 8) ? 8'h00 : 8'hFF;
          if (k == 8) begin
            chk("b2b_bd", 32'(byte_done), 1);
            chk("b2b_no_ur", 32'(underrun), 0);
          end
          get_run(1'b1, n, w);
          chk("b2b_hi", 32'(n), 32'(half_len(v[k % 8])));
          if (k == 8) chk("b2b_gap", 32'(w), 0);
          get_run(1'b0, n, w);
          chk("b2b_lo", 32'(n), 32'(half_len(v[k % 8])));
        end
      end
    join
    chk("b2b_ur_end", 32'(underrun), 1);
    repeat (2) @(negedge clk);
    chk("b2b_ur_cnt", 32'(ur_cnt - ur0), 1);
    chk("b2b_bd_cnt", 32'(bd_cnt - bd0), 2);

    // Motor pause during the 5th clock of a 0-bit HIGH phase
    send(8'h00);
    w = 0;
    while (cas_out !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    n = 0;
    while (cas_out === 1'b1 && n < 500) begin
      n++;
      if (n == 5) motor = 1'b0;
      if (n == 42) motor = 1'b1;
      @(negedge clk);
    end
    chk("pause_hi", 32'(n), 57);
    get_run(1'b0, n, w);
    chk("pause_lo", 32'(n), 20);
    wait_idle();

    // Motor off while a byte is held
    motor = 1'b0;
    send(8'h55);
    repeat (30) @(negedge clk);
    chk("moff_busy", 32'(busy), 0);
    chk("moff_rdy", 32'(u_if.din_ready), 0);
    chk("moff_cas", 32'(cas_out), 0);
    motor = 1'b1;
    repeat (2) @(negedge clk);
    chk("mon_cas", 32'(cas_out), 1);
    chk("mon_busy", 32'(busy), 1);
    wait_idle();

    // Reset during bit 3 with a byte held
    pat = 8'hA5;
    fork
      begin
        send(8'hA5);
        send(8'h3C);
      end
      begin
        for (int i = 0; i < 3; i++) begin
          get_run(1'b1, n, w);
          chk("r6_hi", 32'(n), 32'(half_len(pat[i])));
          get_run(1'b0, n, w);
          chk("r6_lo", 32'(n), 32'(half_len(pat[i])));
        end
        repeat (3) @(negedge clk);
      end
    join
    chk("r6_held", 32'(u_if.din_ready), 0);
    chk("r6_bit3", 32'(cas_out), 1);
    bd0 = bd_cnt;
    reset = 1'b0;
    @(negedge clk);
    chk("r6_cas", 32'(cas_out), 0);
    chk("r6_busy", 32'(busy), 0);
    chk("r6_rdy", 32'(u_if.din_ready), 1);
    chk("r6_bd", 32'(byte_done), 0);
    reset = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy !== 1'b0 || cas_out !== 1'b0) bad++;
    end
    chk("r6_no_resume", 32'(bad), 0);
    chk("r6_bd_cnt", 32'(bd_cnt - bd0), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
